// File: rtl/bignum_pkg.sv
// Shared types for the multi-block magnitude comparison controller and its comparator.
package bignum_pkg;

  typedef enum logic [1:0] {
    CMP_NULL   = 2'b00,
    CMP_A_LT_B = 2'b01,
    CMP_A_GT_B = 2'b10,
    CMP_A_EQ_B = 2'b11
  } cmp_result_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } ctrl_state_t;

endpackage

// File: rtl/running_comparator.sv
// Streams operand blocks LS first and keeps a running magnitude verdict; the verdict
// for the beat being presented is combinational so the final beat can be captured directly.
module running_comparator
  import bignum_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] a_in,
  input  logic [REGISTER_SIZE-1:0] b_in,
  output cmp_result_t              result
);

  localparam int CNT_W = $clog2(NUM_BLOCKS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BLOCKS - 1);

  logic [CNT_W-1:0] count;
  cmp_result_t      acc;

  // A more significant block that differs overrides everything below it.
  always_comb begin
    result = CMP_NULL;
    if (valid_in) begin
      if (a_in > b_in)       result = CMP_A_GT_B;
      else if (a_in < b_in)  result = CMP_A_LT_B;
      else if (count == '0)  result = CMP_A_EQ_B;
      else                   result = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      acc   <= CMP_NULL;
    end else if (valid_in) begin
      if (count == LAST) begin
        count <= '0;
        acc   <= CMP_NULL;
      end else begin
        count <= count + CNT_W'(1);
        acc   <= result;
      end
    end
  end

endmodule

// File: rtl/bignum_compare_controller.sv
// Issues LS-first block reads for two operands, aligns returned data with a valid pipe
// and captures the comparator's final verdict.
//   state | meaning
//   IDLE  | waiting for start_in
//   ISSUE | one read per cycle, NUM_BLOCKS reads
//   DRAIN | reads done, waiting for last beat to leave the valid pipe
//   DONE  | one-cycle done_out pulse
module bignum_compare_controller
  import bignum_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int ADDR_WIDTH    = 10,
  parameter int BRAM_LATENCY  = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [ADDR_WIDTH-1:0]    base_addrA_in,
  input  logic [ADDR_WIDTH-1:0]    base_addrB_in,
  output logic                     bram_rd_en_out,
  output logic [ADDR_WIDTH-1:0]    addrA_out,
  output logic [ADDR_WIDTH-1:0]    addrB_out,
  input  logic [REGISTER_SIZE-1:0] block_numA_in,
  input  logic [REGISTER_SIZE-1:0] block_numB_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [1:0]               result_out
);

  localparam int CNT_W = $clog2(NUM_BLOCKS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BLOCKS - 1);

  ctrl_state_t             state, state_next;
  logic [CNT_W-1:0]        issue_cnt, beat_cnt;
  logic [ADDR_WIDTH-1:0]   base_a, base_b;
  logic [BRAM_LATENCY-1:0] vpipe;
  logic                    rd_en, beat_valid, last_beat;
  cmp_result_t             verdict, result;

  assign beat_valid = vpipe[BRAM_LATENCY-1];
  assign last_beat  = beat_valid && (beat_cnt == LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = ISSUE;
      ISSUE:   if (issue_cnt == LAST) state_next = DRAIN;
      DRAIN:   if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_en    = (state == ISSUE);
    busy_out = (state == ISSUE) || (state == DRAIN);
    done_out = (state == DONE);
  end

  // Issue counter parks on the last index so addresses hold through DRAIN/DONE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      issue_cnt <= '0;
      beat_cnt  <= '0;
      base_a    <= '0;
      base_b    <= '0;
      vpipe     <= '0;
      result    <= CMP_NULL;
    end else begin
      vpipe <= (vpipe << 1) | BRAM_LATENCY'(rd_en);
      if (state == IDLE && start_in) begin
        base_a    <= base_addrA_in;
        base_b    <= base_addrB_in;
        issue_cnt <= '0;
        result    <= CMP_NULL;
      end else if (state == ISSUE && issue_cnt != LAST) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (beat_valid) beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      if (last_beat) result <= verdict;
    end
  end

  assign bram_rd_en_out = rd_en;
  assign addrA_out      = base_a + ADDR_WIDTH'(issue_cnt);
  assign addrB_out      = base_b + ADDR_WIDTH'(issue_cnt);
  assign result_out     = result;

  running_comparator #(
    .REGISTER_SIZE (REGISTER_SIZE),
    .NUM_BLOCKS    (NUM_BLOCKS)
  ) u_cmp (
    .clk      (clk_in),
    .rst      (rst_in),
    .valid_in (beat_valid),
    .a_in     (block_numA_in),
    .b_in     (block_numB_in),
    .result   (verdict)
  );

endmodule

// File: tb/tb_bignum_compare_controller.sv
// Randomized and directed bench: BRAM model plus a whole-number reference model checked every cycle.
module tb_bignum_compare_controller;

  localparam int RS = 32;
  localparam int NB = 4;
  localparam int AW = 10;
  localparam int LAT = 2;
  localparam int DONE_K = NB + LAT + 1;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic start_in = 1'b0;
  logic [AW-1:0] base_addrA_in = '0, base_addrB_in = '0;
  logic bram_rd_en_out;
  logic [AW-1:0] addrA_out, addrB_out;
  logic [RS-1:0] block_numA_in = '0, block_numB_in = '0;
  logic busy_out, done_out;
  logic [1:0] result_out;

  always #5 clk = ~clk;

  bignum_compare_controller #(
    .REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .ADDR_WIDTH(AW), .BRAM_LATENCY(LAT)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .base_addrA_in(base_addrA_in), .base_addrB_in(base_addrB_in),
    .bram_rd_en_out(bram_rd_en_out), .addrA_out(addrA_out), .addrB_out(addrB_out),
    .block_numA_in(block_numA_in), .block_numB_in(block_numB_in),
    .busy_out(busy_out), .done_out(done_out), .result_out(result_out)
  );

  // Behavioural BRAM, two-cycle read latency.
  logic [RS-1:0] mem_a [1024];
  logic [RS-1:0] mem_b [1024];
  logic [RS-1:0] pa = '0, pb = '0;
  always @(posedge clk) begin
    if (bram_rd_en_out) begin
      pa <= mem_a[addrA_out];
      pb <= mem_b[addrB_out];
    end
    block_numA_in <= pa;
    block_numB_in <= pb;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_cmp(input logic [NB*RS-1:0] va, input logic [NB*RS-1:0] vb);
    if (va > vb) return 2'b10;
    if (va < vb) return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [1:0] ref_from_mem(input logic [AW-1:0] ba, input logic [AW-1:0] bb);
    logic [NB*RS-1:0] va, vb;
    for (int i = 0; i < NB; i++) begin
      va[i*RS +: RS] = mem_a[ba + AW'(i)];
      vb[i*RS +: RS] = mem_b[bb + AW'(i)];
    end
    return ref_cmp(va, vb);
  endfunction

  // Reference model: k = cycle index within a run (-1 when idle).
  int k = -1;
  bit model_ok = 1'b0;
  logic [1:0] exp_res = 2'b00, run_verdict = 2'b00;
  logic [AW-1:0] ea = '0, eb = '0;

  always @(posedge clk) begin
    if (rst_in) begin
      k = -1; exp_res = 2'b00; ea = '0; eb = '0; model_ok = 1'b1;
    end else if (k < 0) begin
      if (start_in) begin
        k = 1; exp_res = 2'b00; ea = base_addrA_in; eb = base_addrB_in;
        run_verdict = ref_from_mem(base_addrA_in, base_addrB_in);
      end
    end else if (k == DONE_K) begin
      k = -1;
    end else begin
      if (k < NB) begin ea = ea + 1'b1; eb = eb + 1'b1; end
      k++;
      if (k == DONE_K) exp_res = run_verdict;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("busy", 32'(busy_out), 32'(k >= 1 && k <= NB + LAT));
      chk("done", 32'(done_out), 32'(k == DONE_K));
      chk("rd_en", 32'(bram_rd_en_out), 32'(k >= 1 && k <= NB));
      chk("addrA", 32'(addrA_out), 32'(ea));
      chk("addrB", 32'(addrB_out), 32'(eb));
      chk("result", 32'(result_out), 32'(exp_res));
    end
  end

  task automatic load(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                      input logic [NB*RS-1:0] va, input logic [NB*RS-1:0] vb);
    for (int i = 0; i < NB; i++) begin
      mem_a[ba + AW'(i)] = va[i*RS +: RS];
      mem_b[bb + AW'(i)] = vb[i*RS +: RS];
    end
    base_addrA_in = ba;
    base_addrB_in = bb;
  endtask

  // Call at the negedge of run cycle 1; returns at the negedge of the done cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done_out && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!done_out) chk("done_timeout", 32'(done_out), 32'd1);
  endtask

  task automatic run(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                     input logic [NB*RS-1:0] va, input logic [NB*RS-1:0] vb,
                     output int lat, output logic [1:0] res);
    load(ba, bb, va, vb);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    wait_done(lat);
    res = result_out;
    @(negedge clk);
  endtask

  function automatic logic [RS-1:0] rand_block();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return 32'd1;
      2: return 32'd7;
      3: return '1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, dones;
    logic [1:0] res;
    logic [NB*RS-1:0] va, vb;
    for (int i = 0; i < 1024; i++) begin mem_a[i] = '0; mem_b[i] = '0; end

    // Pin the reference comparison with hand-worked cases (MS block listed first).
    chk("model_eq", 32'(ref_cmp({32'd5, 32'd5, 32'd5, 32'd5}, {32'd5, 32'd5, 32'd5, 32'd5})), 32'd3);
    chk("model_gt", 32'(ref_cmp({32'd9, 32'd1, 32'd1, 32'd1}, {32'd1, 32'd9, 32'd9, 32'd9})), 32'd2);
    chk("model_lt", 32'(ref_cmp({32'd7, 32'd7, 32'd7, 32'd3}, {32'd7, 32'd7, 32'd7, 32'd4})), 32'd1);

    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    chk("reset_result", 32'(result_out), 32'd0);
    chk("reset_busy", 32'(busy_out), 32'd0);
    @(negedge clk);

    run(10'd16, 10'd200, {32'd5, 32'd5, 32'd5, 32'd5}, {32'd5, 32'd5, 32'd5, 32'd5}, lat, res);
    chk("eq_latency", 32'(lat), 32'd7);
    chk("eq_result", 32'(res), 32'd3);
    run(10'd40, 10'd80, {32'd9, 32'd1, 32'd1, 32'd1}, {32'd1, 32'd9, 32'd9, 32'd9}, lat, res);
    chk("ms_dominates", 32'(res), 32'd2);
    run(10'd100, 10'd300, {32'd7, 32'd7, 32'd7, 32'd3}, {32'd7, 32'd7, 32'd7, 32'd4}, lat, res);
    chk("ls_decides", 32'(res), 32'd1);

    // Start re-pulsed during ISSUE and DONE, then a fresh start the cycle after DONE.
    load(10'd500, 10'd600, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd2, 32'd3, 32'd5});
    start_in = 1'b1; @(negedge clk); start_in = 1'b1; @(negedge clk); start_in = 1'b0;
    wait_done(lat);
    chk("restart_first", 32'(result_out), 32'd1);
    load(10'd700, 10'd800, {32'd2, 32'd0, 32'd0, 32'd0}, {32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0});
    start_in = 1'b1; @(negedge clk); @(negedge clk); start_in = 1'b0;
    chk("restart_busy", 32'(busy_out), 32'd1);
    wait_done(lat);
    chk("restart_latency", 32'(lat), 32'd7);
    chk("restart_second", 32'(result_out), 32'd2);
    @(negedge clk);

    // Reset in the second ISSUE cycle aborts the run.
    load(10'd50, 10'd60, {32'd1, 32'd1, 32'd1, 32'd1}, {32'd2, 32'd2, 32'd2, 32'd2});
    start_in = 1'b1; @(negedge clk); start_in = 1'b0;
    @(negedge clk); rst_in = 1'b1;
    @(negedge clk); rst_in = 1'b0;
    chk("abort_busy", 32'(busy_out), 32'd0);
    chk("abort_rd_en", 32'(bram_rd_en_out), 32'd0);
    chk("abort_addrA", 32'(addrA_out), 32'd0);
    dones = 0;
    repeat (12) begin @(negedge clk); if (done_out) dones++; end
    chk("abort_no_done", 32'(dones), 32'd0);
    run(10'd50, 10'd60, {32'd3, 32'd1, 32'd1, 32'd1}, {32'd2, 32'd2, 32'd2, 32'd2}, lat, res);
    chk("after_abort", 32'(res), 32'd2);

    // Address wrap.
    run(10'd1022, 10'd5, {32'd8, 32'd8, 32'd8, 32'd8}, {32'd8, 32'd8, 32'd8, 32'd8}, lat, res);
    chk("wrap_result", 32'(res), 32'd3);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NB; i++) begin
        va[i*RS +: RS] = rand_block();
        vb[i*RS +: RS] = ($urandom_range(0, 2) == 0) ? rand_block() : va[i*RS +: RS];
      end
      run(AW'($urandom), AW'($urandom), va, vb, lat, res);
      chk("rand_latency", 32'(lat), 32'd7);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
